// File: rtl/router7_grant_ctrl.sv
// router7_grant_ctrl: grant controller for the three output merges of the
// 3-port router (parent P, children C1 and C2).
//
// Each output port has its own two-input round-robin arbiter. Once a grant is
// issued, the arbiter keeps it until the packet ends (packet lock). A watchdog
// releases the grant if its holder stops transferring for too long.
//
// Handshake: a requester raises its req bit and keeps it until it sees its
// grant. While the grant is held, a flit moves on every cycle where the port's
// xfer is 1. The grant is released after the edge that samples xfer & tail.
// Releases are registered, so there is always a one-cycle bubble with grant 00
// before the port can grant again. tail without xfer is ignored.
//
// Internal port index: 0 = P, 1 = C1, 2 = C2.
// dbg_busy[i] and dbg_ptr[i] show each arbiter's FSM state and priority
// pointer, so checkers can see them.
module router7_grant_ctrl #(
    parameter int TIMEOUT = 15
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [1:0] C1_req,
    input  logic [1:0] C2_req,
    input  logic [1:0] P_req,
    input  logic       P_xfer,
    input  logic       C1_xfer,
    input  logic       C2_xfer,
    input  logic       P_tail,
    input  logic       C1_tail,
    input  logic       C2_tail,
    output logic [1:0] P_Grant,
    output logic [1:0] C1_Grant,
    output logic [1:0] C2_Grant,
    output logic [2:0] timeout_err,
    output logic [2:0] dbg_busy,
    output logic [2:0] dbg_ptr
);

    // Give the counter at least one bit so that TIMEOUT = 0 still elaborates.
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    // Releasing when the counter would step onto TIMEOUT keeps a stalled
    // grant up for exactly TIMEOUT cycles.
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // If a requester sets both bits, keep only bit0.
    logic [1:0] c1_req_f, c2_req_f, p_req_f;
    assign c1_req_f = C1_req[0] ? 2'b01 : C1_req;
    assign c2_req_f = C2_req[0] ? 2'b01 : C2_req;
    assign p_req_f  = P_req[0]  ? 2'b01 : P_req;

    // Route the filtered requests to each port's In0/In1 inputs.
    logic [2:0] in0, in1, xfer, tail;
    assign in0  = {c1_req_f[0], c2_req_f[0], c1_req_f[1]};
    assign in1  = {p_req_f[1],  p_req_f[0],  c2_req_f[1]};
    assign xfer = {C2_xfer, C1_xfer, P_xfer};
    assign tail = {C2_tail, C1_tail, P_tail};

    logic [1:0] gnt [3];
    assign P_Grant  = gnt[0];
    assign C1_Grant = gnt[1];
    assign C2_Grant = gnt[2];

    for (genvar i = 0; i < 3; i++) begin : g_port
        state_t          state_q, state_d;
        logic [1:0]      gnt_q, gnt_d;
        logic            ptr_q, ptr_d;
        logic [CW-1:0]   cnt_q, cnt_d;
        logic            err_q, err_d;
        logic            wd_hit;

        // The stall limit is reached on this edge. The FSM only acts on it in BUSY.
        assign wd_hit = (TIMEOUT > 0) && (cnt_q == CNT_LAST) && !xfer[i];

        // Arbiter state register. Reset clears grants at once, without waiting for a clock edge.
        always_ff @(posedge CLK or posedge RESET) begin
            if (RESET) begin
                state_q <= IDLE;
                gnt_q   <= 2'b00;
                ptr_q   <= 1'b0;
                cnt_q   <= '0;
                err_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                gnt_q   <= gnt_d;
                ptr_q   <= ptr_d;
                cnt_q   <= cnt_d;
                err_q   <= err_d;
            end
        end

        // Next state: arbitrate in IDLE, hold and watch for tail or stall in BUSY.
        always_comb begin
            state_d = state_q;
            gnt_d   = gnt_q;
            ptr_d   = ptr_q;
            cnt_d   = cnt_q;
            err_d   = err_q;
            case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    if (in0[i] && in1[i]) begin
                        gnt_d   = ptr_q ? 2'b10 : 2'b01;
                        state_d = BUSY;
                    end else if (in0[i]) begin
                        gnt_d   = 2'b01;
                        state_d = BUSY;
                    end else if (in1[i]) begin
                        gnt_d   = 2'b10;
                        state_d = BUSY;
                    end
                end
                BUSY: begin
                    if (xfer[i] && tail[i]) begin
                        // A tail takes priority over a timeout on the same edge.
                        gnt_d   = 2'b00;
                        ptr_d   = gnt_q[0];
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else if (wd_hit) begin
                        gnt_d   = 2'b00;
                        ptr_d   = gnt_q[0];
                        cnt_d   = '0;
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else if (xfer[i]) begin
                        cnt_d = '0;
                    end else if (TIMEOUT > 0) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    gnt_d   = 2'b00;
                end
            endcase
        end

        assign gnt[i]         = gnt_q;
        assign timeout_err[i] = err_q;
        assign dbg_busy[i]    = (state_q == BUSY);
        assign dbg_ptr[i]     = ptr_q;
    end

endmodule

// File: doc/router7_grant_ctrl.md
# router7_grant_ctrl

Clocked grant controller for the three merge stages of the 3-port router (parent P, children C1, C2). It collects each decoder's split select as a per-requester request vector, runs an independent two-way round-robin arbiter with packet lock per output port, and drives the one-hot `P_Grant`, `C1_Grant` and `C2_Grant` selects for the output merges. A per-port watchdog force-releases a grant whose holder has stalled.

## Interface
- `TIMEOUT`, default 15: cycles in BUSY with no transfer before forced release. 0 disables the watchdog.
- `CLK`  in  1  clock; all state updates on the rising edge.
- `RESET`  in  1  asynchronous, active-high.
- `C1_req`  in  2  requests from C1: bit0 → C2 output, bit1 → P output.
- `C2_req`  in  2  requests from C2: bit0 → C1 output, bit1 → P output.
- `P_req`  in  2  requests from P: bit0 → C1 output, bit1 → C2 output.
- `P_xfer`, `C1_xfer`, `C2_xfer`  in  1 each  flit accepted at that output port this cycle.
- `P_tail`, `C1_tail`, `C2_tail`  in  1 each  accepted flit is the packet's last; qualified by the matching xfer.
- `P_Grant`  out  2  one-hot; bit0 = C1 (merge In0), bit1 = C2 (In1).
- `C1_Grant`  out  2  one-hot; bit0 = C2 (In0), bit1 = P (In1).
- `C2_Grant`  out  2  one-hot; bit0 = C1 (In0), bit1 = P (In1).
- `timeout_err`  out  3  sticky watchdog flags; bit0 = P port, bit1 = C1 port, bit2 = C2 port.

## Operation
- Request routing:
  - Each requester's vector should be one-hot or zero.
  - If both bits are set, only bit0 is honoured; bit1 is treated as 0.
- Three identical port arbiters, each with two inputs (In0, In1), a priority pointer `ptr` and state IDLE/BUSY:
  - P port: In0 = `C1_req[1]`, In1 = `C2_req[1]`.
  - C1 port: In0 = `C2_req[0]`, In1 = `P_req[0]`.
  - C2 port: In0 = `C1_req[0]`, In1 = `P_req[1]`.
- IDLE:
  - No request: stay IDLE, grant 00.
  - One request: grant it.
  - Two requests: grant input `ptr`.
  - Any grant moves the port to BUSY.
- BUSY:
  - The grant is held constant (packet lock), even if the request drops.
  - On `xfer & tail`: grant goes to 00, `ptr` becomes the other input, port returns to IDLE.
- Watchdog (`TIMEOUT` > 0):
  - Counter clears on entering BUSY and on every `xfer`.
  - Counter increments on each BUSY cycle without `xfer`.
  - When it reaches `TIMEOUT`: release exactly as for a tail, and set the port's `timeout_err` bit.
  - `timeout_err` bits clear only on reset.
  - Counter width is `$clog2(TIMEOUT+1)`; it never wraps.
- `xfer`/`tail` while IDLE are ignored.
- Reset values:
  - All grants 00.
  - All `ptr` = In0.
  - All ports IDLE, counters 0, `timeout_err` 000.
- Reset asserted mid-packet drops grants asynchronously; no state is retained.

## Timing
- Grants are registered. A request sampled in IDLE at edge t shows its grant after edge t.
- Tail accepted at edge t: grant is 00 during cycle t+1. Earliest next grant is after edge t+1, so there is a mandatory one-cycle bubble.
- Watchdog:
  - Release is visible the cycle after the counter reaches `TIMEOUT`.
  - With `TIMEOUT`=15 and no xfer, the grant is high for exactly 15 cycles.
  - `timeout_err` rises in the same cycle the grant drops.
- Ports are fully independent. One requester may hold grants on different ports simultaneously only via separate req bits, which the one-hot rule forbids.
- Simultaneous `tail` and timeout in one cycle: treated as a tail; `timeout_err` is not set.

## Test plan
- Reset, then `C1_req`=10 → `P_Grant`=01 one cycle later. Hold 3 xfers, tail on the 3rd → `P_Grant`=00 next cycle; `ptr` now favours C2.
- `C1_req`=10 and `C2_req`=10 together from reset → `P_Grant`=01. After tail: 00 for one cycle, then 10. After the next tail with both still requesting → 01 (alternation).
- `TIMEOUT`=4, `P_req`=01, no xfer → `C1_Grant`=10 for 4 cycles, then 00 with `timeout_err`=010. A later tail-only packet leaves bit1 set.
- `C2_req` drops to 00 while `C1_Grant`=01 is BUSY → grant stays 01 until `C1_xfer & C1_tail`.
- `P_req`=11 → only `C1_Grant`=10 is issued; `C2_Grant` stays 00.
- All three ports granted, then `RESET` pulsed between edges → all grants 00 immediately. After deassert, `ptr` favours In0 on every port.
